plru_tree_array: RTL and testbench
==================================

Name: plru_tree_array

Overview:
- Clocked, parametrised tree pseudo-LRU replacement-state array for the set-associative caches (ICache first, then DCache).
- Holds one (WAYS-1)-bit PLRU tree per set.
- Accepts hit "touch" updates from the lookup stage and answers victim requests from the refill FSM with a registered way number.
- The victim is marked MRU in the same operation.
- Generalises replacement state to any power-of-two associativity and set count, and adds a freeze control, same-cycle conflict ordering and an optional invalid-way-first policy.

Parameters:
- WAYS, 4, associativity; power of two, 2..16.
- INDEX_BITS, 7, set-index width; SETS = 2**INDEX_BITS.
- POS_BITS, $clog2(WAYS), way-number width; derived localparam, not overridable.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- hold  in  1  freeze; no state update, victim requests ignored
- touch_valid  in  1  hit update request
- touch_index  in  INDEX_BITS  set of the hit
- touch_way  in  POS_BITS  way that hit
- victim_req  in  1  victim selection request
- victim_index  in  INDEX_BITS  set needing refill
- victim_vmask  in  WAYS  per-way valid bits of that set; used only with the optional feature
- victim_valid  out  1  victim_way valid this cycle, 1-cycle pulse
- victim_way  out  POS_BITS  selected way

Behaviour:
- Reset, synchronous, on the clk edge with resetn=0:
  - Every tree bit of every set = 0.
  - victim_valid = 0, victim_way = 0.
  - A request in the reset cycle is dropped; a pending response is cancelled, so victim_valid = 0 in the following cycle.
- Tree encoding:
  - Heap order; node 1 is the root; children of node n are 2n and 2n+1; leaves map to ways 0..WAYS-1, left to right.
  - Node bit 0 means the victim lies in the left (lower-way) subtree; 1 means the right subtree.
- Victim walk: from the root, follow the node bits for POS_BITS levels; the path bits, MSB first, form the way number.
- MRU update of way w: on each node of w's root-to-leaf path, set the bit to point away from w (bit = NOT of w's branch bit at that level). Off-path nodes are unchanged.
- Touch: touch_valid=1 and hold=0 at edge T → MRU update of touch_way in touch_index at T. No output.
- Victim:
  - victim_req=1 and hold=0 in cycle T → way computed from the set's tree as it stands after any same-cycle touch.
  - Registered: victim_valid=1 and victim_way valid in cycle T+1 only.
  - The victim way is MRU-updated at edge T.
  - Back-to-back requests are allowed, one per cycle, fully pipelined.
- Same-cycle touch and victim:
  - Same index: touch is applied first, victim is walked from the touched tree, then the victim MRU update is applied on top. Both commit at edge T.
  - Different indices: both are applied independently.
- hold=1: array unchanged; victim_req ignored (victim_valid=0 next cycle); touch dropped. An in-flight response from cycle T-1 still appears.
- X-free: an index beyond SETS cannot occur (full decode). touch_way is always in range because WAYS is a power of two.
- Latency: touch 0 cycles of visible output (state updates at the edge); victim 1 cycle.

Optional Feature:
- Macro: PLRU_INVALID_FIRST_EN.
- Defined: if victim_vmask != all-ones, the victim is the lowest-numbered way with vmask bit 0. The tree is still MRU-updated for that way. Tree-walk result is discarded.
- Not defined: victim_vmask is ignored (port kept, unused); the pure tree walk is always used.

Test Plan:
- Reset, then victim_req on index 5 for 4 consecutive cycles (WAYS=4) → victim_way = 0, 2, 1, 3 in cycles T+1..T+4, victim_valid=1 each cycle.
- Reset; touch index 9 way 0; then touch way 2; then victim_req index 9 → victim_way=1. Index 10 in the same cycles → victim_way=0 (independent sets).
- Reset; same cycle touch_valid index 3 way 0 and victim_req index 3 → victim_way=2; a next-cycle victim_req on index 3 → victim_way=1.
- hold=1 with touch index 4 way 0 and victim_req index 4 → victim_valid=0. Release hold and request index 4 → victim_way=0 (state untouched).
- Victims 0 and 2 taken on index 7, resetn=0 asserted for 1 cycle during a pending request → victim_valid=0 the next cycle; a subsequent request on index 7 → victim_way=0.
- With PLRU_INVALID_FIRST_EN: reset, touch index 1 way 3, victim_req index 1 with vmask=4'b1011 → victim_way=2. vmask=4'b1111 → tree walk result, way 0.

Source files
------------

// File: rtl/plru_tree_array_if.sv
// Replacement-state access bundle for plru_tree_array.
// master: lookup stage + refill FSM side; slave: the PLRU array.
interface plru_tree_array_if #(
    parameter int WAYS       = 4,
    parameter int INDEX_BITS = 7
);
    localparam int POS_BITS = $clog2(WAYS);

    logic                  hold;
    logic                  touch_valid;
    logic [INDEX_BITS-1:0] touch_index;
    logic [POS_BITS-1:0]   touch_way;
    logic                  victim_req;
    logic [INDEX_BITS-1:0] victim_index;
    logic [WAYS-1:0]       victim_vmask;
    logic                  victim_valid;
    logic [POS_BITS-1:0]   victim_way;

    modport master (
        output hold, touch_valid, touch_index, touch_way,
        output victim_req, victim_index, victim_vmask,
        input  victim_valid, victim_way
    );

    modport slave (
        input  hold, touch_valid, touch_index, touch_way,
        input  victim_req, victim_index, victim_vmask,
        output victim_valid, victim_way
    );
endinterface

// File: rtl/plru_tree_array.sv
// Tree pseudo-LRU state array: one (WAYS-1)-bit heap-ordered tree per set.
// Ports: clk, resetn (sync, active low), bus (plru_tree_array_if.slave):
//   hold freezes state; touch_* marks a hit way MRU; victim_req/index/vmask
//   request a victim, answered next cycle on victim_valid/victim_way.
// Optional macro PLRU_INVALID_FIRST_EN: pick lowest invalid way if any.
module plru_tree_array #(
    parameter int WAYS       = 4,
    parameter int INDEX_BITS = 7
) (
    input  logic                    clk,
    input  logic                    resetn,
    plru_tree_array_if.slave        bus
);
    localparam int POS_BITS = $clog2(WAYS);
    localparam int SETS     = 2 ** INDEX_BITS;

    if (WAYS < 2 || WAYS > 16 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
        $error("plru_tree_array: WAYS must be a power of two in 2..16");
    end

    // Node n lives at bit n; bit 0 does not exist (root is node 1).
    typedef logic [WAYS-1:1] tree_t;
    typedef logic [POS_BITS-1:0] way_t;

    tree_t [SETS-1:0] tree_q, tree_d;
    logic             victim_valid_q, victim_valid_d;
    way_t             victim_way_q, victim_way_d;

    function automatic way_t walk(tree_t t);
        int   n;
        logic b;
        walk = '0;
        n    = 1;
        for (int l = 0; l < POS_BITS; l++) begin
            b                   = t[n];
            walk[POS_BITS-1-l]  = b;
            n                   = b ? 2 * n + 1 : 2 * n;
        end
    endfunction

    // Every node on w's path is pointed at the sibling subtree.
    function automatic tree_t mru(tree_t t, way_t w);
        int   n;
        logic b;
        mru = t;
        n   = 1;
        for (int l = 0; l < POS_BITS; l++) begin
            b      = w[POS_BITS-1-l];
            mru[n] = ~b;
            n      = b ? 2 * n + 1 : 2 * n;
        end
    endfunction

`ifdef PLRU_INVALID_FIRST_EN
    function automatic way_t first_zero(logic [WAYS-1:0] m);
        first_zero = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!m[i]) first_zero = way_t'(i);
        end
    endfunction
`else
    logic unused_vmask;
    assign unused_vmask = ^bus.victim_vmask;
`endif

    logic  touch_fire;
    logic  victim_fire;
    tree_t touch_tree;
    tree_t victim_base;
    tree_t victim_tree;
    way_t  pick;

    always_comb begin
        touch_fire  = bus.touch_valid & ~bus.hold;
        victim_fire = bus.victim_req & ~bus.hold;
        touch_tree  = mru(tree_q[bus.touch_index], bus.touch_way);

        // Same-set touch is visible to the victim walk of the same cycle.
        if (touch_fire && (bus.touch_index == bus.victim_index)) begin
            victim_base = touch_tree;
        end else begin
            victim_base = tree_q[bus.victim_index];
        end

        pick = walk(victim_base);
`ifdef PLRU_INVALID_FIRST_EN
        if (!(&bus.victim_vmask)) begin
            pick = first_zero(bus.victim_vmask);
        end
`endif
        victim_tree = mru(victim_base, pick);

        // Victim write goes last so it wins on a shared index; it
        // already contains the touch update.
        tree_d = tree_q;
        if (touch_fire) begin
            tree_d[bus.touch_index] = touch_tree;
        end
        if (victim_fire) begin
            tree_d[bus.victim_index] = victim_tree;
        end

        victim_valid_d = victim_fire;
        victim_way_d   = victim_fire ? pick : victim_way_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tree_q         <= '0;
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
        end else begin
            tree_q         <= tree_d;
            victim_valid_q <= victim_valid_d;
            victim_way_q   <= victim_way_d;
        end
    end

    assign bus.victim_valid = victim_valid_q;
    assign bus.victim_way   = victim_way_q;
endmodule

// File: tb/tb_plru_tree_array.sv
// Randomised + directed bench for plru_tree_array (WAYS=4, INDEX_BITS=7)
// against a per-set node-bit reference model.
module tb_plru_tree_array;
    localparam int WAYS       = 4;
    localparam int INDEX_BITS = 7;
    localparam int POS_BITS   = 2;
    localparam int SETS       = 128;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    plru_tree_array_if #(.WAYS(WAYS), .INDEX_BITS(INDEX_BITS)) bus ();

    plru_tree_array #(.WAYS(WAYS), .INDEX_BITS(INDEX_BITS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: node bits per set, node n in 1..WAYS-1.
    bit mtree [SETS][WAYS];
    bit exp_valid;
    int exp_way;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_clear();
        foreach (mtree[i, j]) mtree[i][j] = 1'b0;
    endfunction

    function automatic int m_walk(int s);
        int n = 1;
        while (n < WAYS) n = 2 * n + int'(mtree[s][n]);
        return n - WAYS;
    endfunction

    // Climb from the leaf: each ancestor points away from the child we came from.
    function automatic void m_mru(int s, int w);
        int leaf = WAYS + w;
        for (int l = 1; l <= POS_BITS; l++) begin
            int node  = leaf >> l;
            int child = leaf >> (l - 1);
            mtree[s][node] = ((child % 2) == 0);
        end
    endfunction

    function automatic int m_pick(int s, int vm);
`ifdef PLRU_INVALID_FIRST_EN
        for (int i = 0; i < WAYS; i++) begin
            if (((vm >> i) & 1) == 0) return i;
        end
`endif
        return m_walk(s);
    endfunction

    task automatic drive(input bit h, input bit tv, input int ti, input int tw,
                         input bit vr, input int vi, input int vm);
        bus.hold         = h;
        bus.touch_valid  = tv;
        bus.touch_index  = INDEX_BITS'(ti);
        bus.touch_way    = POS_BITS'(tw);
        bus.victim_req   = vr;
        bus.victim_index = INDEX_BITS'(vi);
        bus.victim_vmask = WAYS'(vm);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 15);
    endtask

    // One clock: update the model with the inputs seen at the edge, then check.
    task automatic cyc();
        @(posedge clk);
        if (!resetn) begin
            m_clear();
            exp_valid = 0;
        end else if (!bus.hold) begin
            if (bus.touch_valid) m_mru(int'(bus.touch_index), int'(bus.touch_way));
            if (bus.victim_req) begin
                exp_way = m_pick(int'(bus.victim_index), int'(bus.victim_vmask));
                m_mru(int'(bus.victim_index), exp_way);
                exp_valid = 1;
            end else begin
                exp_valid = 0;
            end
        end else begin
            exp_valid = 0;
        end
        #1;
        check("valid", int'(bus.victim_valid), int'(exp_valid));
        if (exp_valid) check("way", int'(bus.victim_way), exp_way);
    endtask

    task automatic do_reset();
        resetn = 0;
        idle();
        cyc();
        resetn = 1;
    endtask

    int tp1 [4] = '{0, 2, 1, 3};

    initial begin
        resetn = 0;
        idle();
        cyc();
        cyc();
        check("rst_valid", int'(bus.victim_valid), 0);
        check("rst_way", int'(bus.victim_way), 0);
        resetn = 1;

        // Sweep of a fresh set.
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 5, 15);
            cyc();
            check("tp1_way", int'(bus.victim_way), tp1[i]);
        end
        idle();
        cyc();

        // Touches, then victims in touched and untouched sets.
        do_reset();
        drive(0, 1, 9, 0, 0, 0, 15); cyc();
        drive(0, 1, 9, 2, 0, 0, 15); cyc();
        drive(0, 0, 0, 0, 1, 9, 15); cyc();
        check("tp2_way9", int'(bus.victim_way), 1);
        drive(0, 0, 0, 0, 1, 10, 15); cyc();
        check("tp2_way10", int'(bus.victim_way), 0);

        // Same-cycle touch and victim on one set.
        do_reset();
        drive(0, 1, 3, 0, 1, 3, 15); cyc();
        check("tp3_same", int'(bus.victim_way), 2);
        drive(0, 0, 0, 0, 1, 3, 15); cyc();
        check("tp3_next", int'(bus.victim_way), 1);

        // Hold freezes everything.
        do_reset();
        drive(1, 1, 4, 0, 1, 4, 15); cyc();
        check("tp4_hold", int'(bus.victim_valid), 0);
        drive(0, 0, 0, 0, 1, 4, 15); cyc();
        check("tp4_way", int'(bus.victim_way), 0);

        // Reset cancels the pending response and clears state.
        do_reset();
        drive(0, 0, 0, 0, 1, 7, 15); cyc();
        drive(0, 0, 0, 0, 1, 7, 15); cyc();
        check("tp5_second", int'(bus.victim_way), 2);
        resetn = 0;
        cyc();
        check("tp5_cancel", int'(bus.victim_valid), 0);
        resetn = 1;
        cyc();
        check("tp5_way", int'(bus.victim_way), 0);

`ifdef PLRU_INVALID_FIRST_EN
        do_reset();
        drive(0, 1, 1, 3, 0, 0, 15); cyc();
        drive(0, 0, 0, 0, 1, 1, 4'b1011); cyc();
        check("tp6_inval", int'(bus.victim_way), 2);
        drive(0, 0, 0, 0, 1, 1, 4'b1111); cyc();
        check("tp6_tree", int'(bus.victim_way), 0);
`endif

        // Random traffic over a few sets so collisions are common.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            resetn = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7),
                  $urandom_range(0, WAYS - 1),
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 7),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 15);
            cyc();
        end
        resetn = 1;
        idle();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
